// File: rtl/sa_operand_feeder.sv
// Buffers one N x N A and B matrix from a byte stream, then feeds them diagonally skewed into a systolic array.
// Start-to-done takes 3N cycles; in_ready is high only while loading (IDLE); bytes offered in any other state are dropped.
module sa_operand_feeder #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          start,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic          feed_valid,
  output logic          acc_clr,
  output logic          busy,
  output logic          done
);

  localparam int NN = N * N;
  localparam int CW = $clog2(2 * NN) + 1;
  localparam int SW = $clog2(2 * N) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FULL, S_CLEAR, S_FEED, S_FLUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [SW-1:0]     r_step, w_step_nxt;
  logic [NN*DW-1:0]  r_a, r_b;
  logic              w_accept;
  int                w_t;
  logic [N*DW-1:0]   w_a_nxt, w_b_nxt;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_t      = int'(w_step_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CW'(2 * NN - 1)) w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_step_nxt  = '0;
      end
      S_FEED: begin
        if (r_step == SW'(2 * N - 2)) begin
          w_state_nxt = S_FLUSH;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_step == SW'(N - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_step_nxt  = '0;
      end
    endcase
  end

  // Operands are decoded from the next step so the registered edge shows step t during cycle t.
  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    if (w_state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if (w_t >= i && (w_t - i) < N) begin
          w_a_nxt[i*DW +: DW] = r_a[(i * N + (w_t - i)) * DW +: DW];
          w_b_nxt[i*DW +: DW] = r_b[((w_t - i) * N + i) * DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_cnt < CW'(NN)) r_a[int'(r_cnt) * DW +: DW] <= in_data;
      else                 r_b[(int'(r_cnt) - NN) * DW +: DW] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      a_out      <= '0;
      b_out      <= '0;
      feed_valid <= 1'b0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_ready   <= (w_state_nxt == S_IDLE);
      a_out      <= w_a_nxt;
      b_out      <= w_b_nxt;
      feed_valid <= (w_state_nxt == S_FEED) || (w_state_nxt == S_FLUSH);
      acc_clr    <= (w_state_nxt == S_CLEAR);
      busy       <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FEED) || (w_state_nxt == S_FLUSH);
      done       <= (w_state_nxt == S_FLUSH) && (w_step_nxt == SW'(N - 1));
    end
  end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Scoreboard bench for sa_operand_feeder (N=2): directed loads, expected edge operands and C results queued
// by the stimulus, popped and compared by a negedge monitor that also runs a small output-stationary array.
module tb_sa_operand_feeder;
  localparam int N  = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst, in_valid, start;
  logic [DW-1:0]   in_data;
  logic            in_ready, feed_valid, acc_clr, busy, done;
  logic [N*DW-1:0] a_out, b_out;

  always #5 clk = ~clk;

  sa_operand_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .a_out(a_out), .b_out(b_out), .feed_valid(feed_valid),
    .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic        clr;
    logic        fv;
    logic        dn;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] c_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Expected edge sequence of one full transfer: clear, 3 feed steps, 2 flush cycles.
  task automatic push_full(input logic [15:0] a0, b0, a1, b1, a2, b2, input logic [31:0] c);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, a0, b0});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, a1, b1});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, a2, b2});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 16'h0, 16'h0});
    exp_q.push_back('{1'b0, 1'b1, 1'b1, 16'h0, 16'h0});
    c_q.push_back(c);
  endtask

  // Downstream array model: a moves east, b moves south, each PE accumulates a*b.
  int          acc [2][2];
  logic [7:0]  ar [2][2], br [2][2], na [2][2], nb [2][2];
  logic [7:0]  ain, bin;
  exp_t        mon_e;
  logic [31:0] mon_c;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc[i][j] = 0; ar[i][j] = 8'h0; br[i][j] = 8'h0;
      end
  end

  always @(negedge clk) begin
    if (acc_clr === 1'b1 || feed_valid === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got clr=%b fv=%b done=%b a=%h b=%h want nothing",
                 acc_clr, feed_valid, done, a_out, b_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("edge_step", {acc_clr, feed_valid, done, a_out, b_out}, mon_e);
      end
    end
    if (acc_clr === 1'b1) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          acc[i][j] = 0; ar[i][j] = 8'h0; br[i][j] = 8'h0;
        end
    end else if (feed_valid === 1'b1) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          if (j == 0) ain = a_out[i*8 +: 8];
          else        ain = ar[i][j-1];
          if (i == 0) bin = b_out[j*8 +: 8];
          else        bin = br[i-1][j];
          acc[i][j] = acc[i][j] + int'(ain) * int'(bin);
          na[i][j] = ain;
          nb[i][j] = bin;
        end
      ar = na;
      br = nb;
    end
    if (done === 1'b1) begin
      if (c_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 want no result pending");
      end else begin
        mon_c = c_q.pop_front();
        check("c00", acc[0][0], mon_c[7:0]);
        check("c01", acc[0][1], mon_c[15:8]);
        check("c10", acc[1][0], mon_c[23:16]);
        check("c11", acc[1][1], mon_c[31:24]);
      end
    end
  end

  // Bytes go out LSB first: A row-major then B row-major.
  task automatic load(input logic [63:0] v, input bit gap, input bit start_with);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = v[k*8 +: 8];
      start    = start_with;
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      if (k == 6) check("in_ready_before_last", in_ready, 1);
      if (gap && k < 7) begin
        @(posedge clk); #1;
      end
    end
    check("in_ready_after_last", in_ready, 0);
  endtask

  task automatic run(input bit junk_bytes, input bit keep_start);
    int cnt;
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    if (junk_bytes) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 4) in_valid = 1'b0;
      if (done === 1'b1) break;
    end
    in_valid = 1'b0;
    check("start_to_done", cnt, 3 * N);
    @(posedge clk); #1;
    check("in_ready_after_done", in_ready, 1);
    check("busy_after_done", busy, 0);
  endtask

  localparam logic [63:0] AB_BYTES  = 64'h0807060504030201;
  localparam logic [63:0] ID_BYTES  = 64'h0100000101000001;
  localparam logic [31:0] AB_C      = 32'h322B1613;
  localparam logic [31:0] ID_C      = 32'h01000001;

  initial begin
    rst = 1'b1; in_valid = 1'b0; start = 1'b0; in_data = 8'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);
    check("rst_feed_valid", feed_valid, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // start during IDLE and with the last byte must not launch; FULL ignores bytes.
    load(AB_BYTES, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("full_hold_busy", busy, 0);
    check("full_hold_in_ready", in_ready, 0);
    push_full(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, AB_C);
    run(1'b1, 1'b0);

    // Gapped load, start held high through the whole transfer and into IDLE.
    load(AB_BYTES, 1'b1, 1'b0);
    push_full(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, AB_C);
    run(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    check("held_start_idle_busy", busy, 0);

    // Reset during FEED step t=1.
    load(AB_BYTES, 1'b0, 1'b0);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 16'h0001, 16'h0005});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 16'h0302, 16'h0607});
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_a_out", a_out, 0);
    check("midrst_b_out", b_out, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_feed_valid", feed_valid, 0);
    check("midrst_done", done, 0);
    repeat (5) @(posedge clk);
    #1;
    load(AB_BYTES, 1'b0, 1'b0);
    push_full(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, AB_C);
    run(1'b0, 1'b0);

    // Back-to-back identity load straight after done.
    load(ID_BYTES, 1'b0, 1'b0);
    push_full(16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0100, 16'h0100, ID_C);
    run(1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("edge_queue_drained", exp_q.size(), 0);
    check("c_queue_drained", c_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sa_operand_feeder.md
# sa_operand_feeder

Upstream operand stage for the systolic array core. Accepts a byte stream holding one N×N operand matrix A and one N×N matrix B, buffers both, then drives them into the array's west (A rows) and north (B columns) edges with the diagonal skew an output-stationary array needs. One transfer computes C = A·B; the array accumulates and `done` tells the result drain when the last operands have entered.

## Interface
Parameters:
- N, 2, array dimension (rows = columns); legal 2..4
- DW, 8, operand width in bits

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  byte strobe from the pin-level front end
- in_data  in  DW  operand byte
- in_ready  out  1  high while the buffer accepts bytes
- start  in  1  request to begin feeding; honoured only in FULL
- a_out  out  N*DW  west edge; slice [i*DW +: DW] drives row i
- b_out  out  N*DW  north edge; slice [j*DW +: DW] drives column j
- feed_valid  out  1  array enable: high in FEED and FLUSH
- acc_clr  out  1  one-cycle accumulator clear to every PE
- busy  out  1  high in CLEAR, FEED, FLUSH
- done  out  1  one-cycle pulse at end of FLUSH

## Operation
- All outputs are registered; reset value of every output is 0 except `in_ready`, which is 1 (IDLE).
- Load order: 2·N² bytes; the first N² are A row-major (A[0][0], A[0][1], …), the next N² are B row-major. A byte is accepted on any edge where in_valid && in_ready. Load counter is log2(2N²)+1 bits.
- States:
  - IDLE: in_ready=1. Accepts bytes; on acceptance of byte 2N²−1 go to FULL. `start` ignored.
  - FULL: in_ready=0; in_valid ignored. start=1 → CLEAR.
  - CLEAR: 1 cycle, acc_clr=1, a_out/b_out=0 → FEED.
  - FEED: step counter t = 0..2N−2. Row i presents A[i][t−i] when 0 ≤ t−i < N, else 0. Column j presents B[t−j][j] when 0 ≤ t−j < N, else 0. After t=2N−2 → FLUSH.
  - FLUSH: N cycles of all-zero operands with feed_valid=1, so operands propagate to PE(N−1,N−1). On the last FLUSH cycle done=1, then → IDLE with load counter cleared.
- Buffers are not cleared on return to IDLE; they are overwritten by the next load.
- Operand values are passed unmodified (no sign handling in this block).

## Timing
- If start is sampled at edge k in FULL: acc_clr high in cycle k+1; FEED occupies cycles k+2 .. k+2N; FLUSH occupies k+2N+1 .. k+3N; done high in cycle k+3N; in_ready returns high in cycle k+3N+1.
- Transfer latency, start to done: 3N cycles (N=2: 6).
- The byte-to-FULL transition: in_ready drops in the cycle after the last byte is accepted.
- in_valid and start together in IDLE: byte accepted, start ignored (even with the last byte).
- start held high through FEED/FLUSH/IDLE: no effect; a second transfer needs a full reload.
- rst in any state: next cycle is IDLE with load counter 0, all outputs at reset values; a partial load or an in-progress feed is abandoned and done is not pulsed.

## Test plan
- N=2, load A=[[1,2],[3,4]], B=[[5,6],[7,8]] with start: acc_clr for 1 cycle, then rows (row0,row1)/cols (col0,col1) show t0: a=(1,0) b=(5,0); t1: a=(2,3) b=(7,6); t2: a=(0,4) b=(0,8); then 2 zero FLUSH cycles, done in the last one; downstream array yields C=[[19,22],[43,50]].
- Gapped load: in_valid toggled every other cycle across the 8 bytes → same FEED pattern as above; in_ready low from the cycle after byte 8.
- start asserted during IDLE and together with the last byte → no CLEAR; FULL is held until a separate start pulse.
- Bytes driven while FULL/FEED (value 0xFF) → ignored; FEED pattern unchanged.
- rst asserted mid-FEED (t=1) → next cycle all outputs 0, in_ready=1, no done; a fresh 8-byte load plus start then runs correctly.
- Back-to-back: second load of A=B=identity right after done → FEED t0 a=(1,0) b=(1,0), t1 a=(0,0) b=(0,0), t2 a=(0,1) b=(0,1).
